program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Instruction-side writer for the core's program memory. It accepts decoded instruction fields over a valid/ready handshake and encodes them into 32-bit RV32I machine words in the R/I/S/B/U/J/SYS layouts. It writes the words to consecutive program-memory addresses, starting at 0. It is the producer counterpart of the fetch/decode path and is used by boot and testbench flows to load programs.

Parameters:
INSTRUCTION_WIDTH, 32, encoded word width; fixed by the ISA.
PROGRAM_ADDRESS_WIDTH, 6, program-memory address width; depth is 2**PROGRAM_ADDRESS_WIDTH (64).

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse; clears counter and errors, enters LOAD
finish  in  1  pulse; ends the load session
in_valid  in  1  instruction fields are valid
in_ready  out  1  block accepts the fields this cycle
in_fmt  in  3  instruction_op_type: R_TYPE=0, I_TYPE=1, S_TYPE=2, B_TYPE=3, U_TYPE=4, J_TYPE=5, SYS_TYPE=6
in_opcode  in  7  opcode field
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field
in_imm  in  32  immediate, sign-extended byte offset / value
mem_we  out  1  program-memory write strobe
mem_addr  out  PROGRAM_ADDRESS_WIDTH  write address
mem_wdata  out  INSTRUCTION_WIDTH  encoded instruction word
count  out  PROGRAM_ADDRESS_WIDTH+1  number of words written this session (0..64)
full  out  1  count == 64
done  out  1  one-cycle pulse when a session ends
err_fmt  out  1  sticky; set when in_fmt == 7
err_align  out  1  sticky; set when a B/J immediate has imm[0] == 1

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, sticky errors cleared. A write that is in flight when reset is asserted is lost; mem_we is 0 on the next cycle.
- States and transitions:
  - IDLE: start -> LOAD. finish is ignored.
  - LOAD: start -> LOAD, with the counter and errors cleared. finish -> IDLE, with done pulsed on the next cycle. An accepted write that brings count to 64 -> FULL.
  - FULL: start -> LOAD with the counter cleared. finish -> IDLE with done pulsed.
- in_ready = (state == LOAD) && !full && !start && !finish. This is combinational. start has priority over finish, and both have priority over an accept.
- Accept occurs when in_valid && in_ready.
- Latency: one registered stage. For an accept in cycle N, mem_we = 1 in cycle N+1, with mem_addr = write pointer and mem_wdata = encoded word. An in-flight write still completes if finish or start is asserted in cycle N+1.
- Write pointer and counter increment once per committed write. The pointer wraps naturally from 63 to 0, but that wrap is never reached because the block enters FULL.
- Encoding rules (bit positions high to low; imm is in_imm):
  - R_TYPE: funct7 | rs2 | rs1 | funct3 | rd | opcode
  - I_TYPE and SYS_TYPE: imm[11:0] | rs1 | funct3 | rd | opcode
  - S_TYPE: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  - B_TYPE: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
  - U_TYPE: imm[31:12] | rd | opcode
  - J_TYPE: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode
  - Immediate bits outside these slices are ignored; no range check is made.
- Error handling:
  - in_fmt == 7: the handshake completes, but no write occurs, the counter does not advance, and err_fmt is set.
  - B_TYPE or J_TYPE with imm[0] == 1: the handshake completes, but no write occurs, and err_align is set.
  - Both error flags clear only on start or reset.
- A back-to-back stream sustains 1 word per cycle, with a continuously high in_ready until full.

Test Plan:
- reset, start, then one I_TYPE accept: ADDI x1,x0,5 (opcode 0010011, rd=1, rs1=0, f3=0, imm=5) -> next cycle mem_we=1, addr=0, wdata=0x00500093, count=1.
- Stream of five instructions in consecutive cycles:
  - ADD x3,x1,x2 -> 0x002081B3
  - SW x2,8(x1) -> 0x0020A423
  - BEQ x1,x2,+8 -> 0x00208463
  - LUI x5,0x12345 (imm=0x12345000) -> 0x123452B7
  - JAL x1,+16 -> 0x010000EF
  - Required response: addresses 0..4 in order, one write per cycle, in_ready held high throughout.
- 64 accepts: full=1, count=64 and in_ready=0 in the cycle after the 64th write; a 65th in_valid is not accepted and no write occurs. Then finish -> done pulses once and state returns to IDLE.
- in_fmt=7 and a BEQ with imm=3: neither produces a write, err_fmt=1 and err_align=1, count unchanged. A following start clears both flags and count.
- start and finish asserted in the same cycle while in LOAD, with in_valid=1: no accept, counter reset to 0, state stays LOAD, no done pulse.
- reset asserted in the cycle after an accept: mem_we=0 on the following cycle and count=0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: encodes decoded RV32I instruction fields into machine words
// and writes them to consecutive program-memory addresses starting at 0.
module program_loader #(
  parameter int INSTRUCTION_WIDTH     = 32,
  parameter int PROGRAM_ADDRESS_WIDTH = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             finish,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2:0]                       in_fmt,
  input  logic [6:0]                       in_opcode,
  input  logic [4:0]                       in_rd,
  input  logic [4:0]                       in_rs1,
  input  logic [4:0]                       in_rs2,
  input  logic [2:0]                       in_funct3,
  input  logic [6:0]                       in_funct7,
  input  logic [31:0]                      in_imm,
  output logic                             mem_we,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0] mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0]     mem_wdata,
  output logic [PROGRAM_ADDRESS_WIDTH:0]   count,
  output logic                             full,
  output logic                             done,
  output logic                             err_fmt,
  output logic                             err_align
);

  localparam int AW = PROGRAM_ADDRESS_WIDTH;
  // count value when every memory slot holds a word, and the one just before
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  localparam logic [2:0] R_TYPE   = 3'd0;
  localparam logic [2:0] I_TYPE   = 3'd1;
  localparam logic [2:0] S_TYPE   = 3'd2;
  localparam logic [2:0] B_TYPE   = 3'd3;
  localparam logic [2:0] U_TYPE   = 3'd4;
  localparam logic [2:0] J_TYPE   = 3'd5;
  localparam logic [2:0] SYS_TYPE = 3'd6;
  localparam logic [2:0] BAD_TYPE = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  // registered write stage: one entry, sits between accept and memory
  typedef struct packed {
    logic                         we;
    logic [AW-1:0]                addr;
    logic [INSTRUCTION_WIDTH-1:0] data;
  } wr_t;

  state_t                 state, state_nxt;
  wr_t                    wr_q;
  logic [AW:0]            cnt;
  logic [AW-1:0]          wptr;
  logic [31:0]            word;
  logic                   accept, bad_fmt, bad_align, commit;

  assign full     = (cnt == CNT_FULL);
  assign count    = cnt;
  // start beats finish, and both beat a new accept
  assign in_ready = (state == S_LOAD) && !full && !start && !finish;
  assign accept   = in_valid && in_ready;

  // malformed requests complete the handshake but never reach memory
  assign bad_fmt   = (in_fmt == BAD_TYPE);
  assign bad_align = ((in_fmt == B_TYPE) || (in_fmt == J_TYPE)) && in_imm[0];
  assign commit    = accept && !bad_fmt && !bad_align;

  assign mem_we    = wr_q.we;
  assign mem_addr  = wr_q.addr;
  assign mem_wdata = wr_q.data;

  // field packing for each instruction layout
  always_comb begin
    word = '0;
    case (in_fmt)
      R_TYPE:           word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      I_TYPE, SYS_TYPE: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      S_TYPE:           word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      B_TYPE:           word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
      U_TYPE:           word = {in_imm[31:12], in_rd, in_opcode};
      J_TYPE:           word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
      default:          word = '0;
    endcase
  end

  // session control: start always restarts a load, finish closes it
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (start)                             state_nxt = S_LOAD;
        else if (finish)                       state_nxt = S_IDLE;
        else if (commit && (cnt == CNT_LAST))  state_nxt = S_FULL;
      end
      S_FULL: begin
        if (start)       state_nxt = S_LOAD;
        else if (finish) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register and end-of-session pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish && !start && (state != S_IDLE);
    end
  end

  // write stage: an accepted word is presented to memory the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
    end else begin
      wr_q.we <= commit;
      if (commit) begin
        wr_q.addr <= wptr;
        wr_q.data <= word;
      end
    end
  end

  // pointer, word count and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      wptr      <= '0;
      err_fmt   <= 1'b0;
      err_align <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      wptr      <= '0;
      err_fmt   <= 1'b0;
      err_align <= 1'b0;
    end else begin
      if (commit) begin
        cnt  <= cnt + 1'b1;
        wptr <= wptr + 1'b1;
      end
      if (accept && bad_fmt)   err_fmt   <= 1'b1;
      if (accept && bad_align) err_align <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized checks of program_loader against
// an arithmetic model of the RV32I field layouts.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;
  logic        full, done, err_fmt, err_align;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } instr_t;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .done(done),
    .err_fmt(err_fmt), .err_align(err_align)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // reference encoder: place each field by multiplying up to its bit offset
  function automatic logic [31:0] enc(instr_t t);
    logic [31:0] im, w, hdr;
    im  = t.imm;
    hdr = t.rd * 32'd128 + 32'(t.op);
    case (t.fmt)
      3'd0: w = t.f7 * 32'h0200_0000 + t.rs2 * 32'h10_0000 + t.rs1 * 32'h8000 +
                t.f3 * 32'h1000 + hdr;
      3'd1, 3'd6: w = (im % 32'd4096) * 32'h10_0000 + t.rs1 * 32'h8000 +
                      t.f3 * 32'h1000 + hdr;
      3'd2: w = ((im / 32) % 128) * 32'h0200_0000 + t.rs2 * 32'h10_0000 +
                t.rs1 * 32'h8000 + t.f3 * 32'h1000 + (im % 32) * 128 + 32'(t.op);
      3'd3: w = ((im / 4096) % 2) * 32'h8000_0000 + ((im / 32) % 64) * 32'h0200_0000 +
                t.rs2 * 32'h10_0000 + t.rs1 * 32'h8000 + t.f3 * 32'h1000 +
                ((im / 2) % 16) * 256 + ((im / 2048) % 2) * 128 + 32'(t.op);
      3'd4: w = (im / 4096) * 4096 + hdr;
      3'd5: w = ((im / 32'h10_0000) % 2) * 32'h8000_0000 + ((im / 2) % 1024) * 32'h20_0000 +
                ((im / 2048) % 2) * 32'h10_0000 + ((im / 4096) % 256) * 32'h1000 + hdr;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic rand_instr(output instr_t t);
    t.fmt = 3'($urandom_range(0, 6));
    t.op  = 7'($urandom);
    t.rd  = 5'($urandom);
    t.rs1 = 5'($urandom);
    t.rs2 = 5'($urandom);
    t.f3  = 3'($urandom);
    t.f7  = 7'($urandom);
    t.imm = $urandom;
    if (t.fmt == 3'd3 || t.fmt == 3'd5) t.imm[0] = 1'b0;
  endtask

  task automatic mk(output instr_t t, input logic [2:0] fmt, input logic [6:0] op,
                    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [2:0] f3, input logic [31:0] imm);
    t.fmt = fmt; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.f3 = f3; t.f7 = 7'd0; t.imm = imm;
  endtask

  task automatic apply(input instr_t t);
    in_fmt = t.fmt; in_opcode = t.op; in_rd = t.rd; in_rs1 = t.rs1;
    in_rs2 = t.rs2; in_funct3 = t.f3; in_funct7 = t.f7; in_imm = t.imm;
    in_valid = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    total++; if (mem_we !== 1'b0)     $display("FAIL reset_we got=%0h exp=0", mem_we); else passed++;
    total++; if (mem_addr !== 6'd0)   $display("FAIL reset_addr got=%0h exp=0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'd0) $display("FAIL reset_wdata got=%0h exp=0", mem_wdata); else passed++;
    total++; if (count !== 7'd0)      $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (full !== 1'b0)       $display("FAIL reset_full got=%0h exp=0", full); else passed++;
    total++; if (done !== 1'b0)       $display("FAIL reset_done got=%0h exp=0", done); else passed++;
    total++; if (err_fmt !== 1'b0)    $display("FAIL reset_err_fmt got=%0h exp=0", err_fmt); else passed++;
    total++; if (err_align !== 1'b0)  $display("FAIL reset_err_align got=%0h exp=0", err_align); else passed++;
    total++; if (in_ready !== 1'b0)   $display("FAIL reset_ready got=%0h exp=0", in_ready); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    instr_t t;
    do_start();
    mk(t, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    apply(t);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL single_ready got=%0h exp=1", in_ready); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b1)             $display("FAIL single_we got=%0h exp=1", mem_we); else passed++;
    total++; if (mem_addr !== 6'd0)           $display("FAIL single_addr got=%0h exp=0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0050_0093) $display("FAIL single_wdata got=%08h exp=00500093", mem_wdata); else passed++;
    total++; if (count !== 7'd1)              $display("FAIL single_count got=%0d exp=1", count); else passed++;
    @(negedge clk);
    total++; if (mem_we !== 1'b0) $display("FAIL single_we_drop got=%0h exp=0", mem_we); else passed++;
  endtask

  task automatic test_back_to_back();
    instr_t      prog [5];
    logic [31:0] gold [5];
    mk(prog[0], 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0);          gold[0] = 32'h0020_81B3;
    mk(prog[1], 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);          gold[1] = 32'h0020_A423;
    mk(prog[2], 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);          gold[2] = 32'h0020_8463;
    mk(prog[3], 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);  gold[3] = 32'h1234_52B7;
    mk(prog[4], 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd16);         gold[4] = 32'h0100_00EF;
    do_start();
    for (int i = 0; i < 5; i++) begin
      apply(prog[i]);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, in_ready); else passed++;
      @(negedge clk);
      total++; if (mem_we !== 1'b1)      $display("FAIL b2b_we[%0d] got=%0h exp=1", i, mem_we); else passed++;
      total++; if (mem_addr !== 6'(i))   $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, mem_addr, i); else passed++;
      total++; if (mem_wdata !== gold[i]) $display("FAIL b2b_wdata[%0d] got=%08h exp=%08h", i, mem_wdata, gold[i]); else passed++;
    end
    in_valid = 1'b0;
    total++; if (count !== 7'd5) $display("FAIL b2b_count got=%0d exp=5", count); else passed++;
    @(negedge clk);
  endtask

  task automatic test_fill();
    instr_t      t;
    logic [31:0] exp;
    do_start();
    for (int i = 0; i < 64; i++) begin
      rand_instr(t);
      exp = enc(t);
      apply(t);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL fill_ready[%0d] got=%0h exp=1", i, in_ready); else passed++;
      @(negedge clk);
      total++; if (mem_we !== 1'b1)      $display("FAIL fill_we[%0d] got=%0h exp=1", i, mem_we); else passed++;
      total++; if (mem_addr !== 6'(i))   $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, mem_addr, i); else passed++;
      total++; if (mem_wdata !== exp)    $display("FAIL fill_wdata[%0d] fmt=%0d got=%08h exp=%08h", i, t.fmt, mem_wdata, exp); else passed++;
      total++; if (count !== 7'(i + 1))  $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); else passed++;
    end
    rand_instr(t);
    apply(t);
    #1;
    total++; if (full !== 1'b1)     $display("FAIL fill_full got=%0h exp=1", full); else passed++;
    total++; if (count !== 7'd64)   $display("FAIL fill_count64 got=%0d exp=64", count); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL fill_ready_full got=%0h exp=0", in_ready); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b0)   $display("FAIL fill_65th_we got=%0h exp=0", mem_we); else passed++;
    total++; if (count !== 7'd64)   $display("FAIL fill_65th_count got=%0d exp=64", count); else passed++;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL fill_done got=%0h exp=1", done); else passed++;
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL fill_idle_ready got=%0h exp=0", in_ready); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (done !== 1'b0)   $display("FAIL fill_done_once got=%0h exp=0", done); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL fill_idle_we got=%0h exp=0", mem_we); else passed++;
  endtask

  task automatic test_errors();
    instr_t t;
    do_start();
    mk(t, 3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd7);
    apply(t);
    @(negedge clk);
    rand_instr(t);
    t.fmt = 3'd7;
    apply(t);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL err_fmt_ready got=%0h exp=1", in_ready); else passed++;
    @(negedge clk);
    total++; if (mem_we !== 1'b0)    $display("FAIL err_fmt_we got=%0h exp=0", mem_we); else passed++;
    total++; if (err_fmt !== 1'b1)   $display("FAIL err_fmt_flag got=%0h exp=1", err_fmt); else passed++;
    total++; if (err_align !== 1'b0) $display("FAIL err_fmt_align got=%0h exp=0", err_align); else passed++;
    total++; if (count !== 7'd1)     $display("FAIL err_fmt_count got=%0d exp=1", count); else passed++;
    mk(t, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    apply(t);
    @(negedge clk);
    total++; if (mem_we !== 1'b0)    $display("FAIL err_align_we got=%0h exp=0", mem_we); else passed++;
    total++; if (err_align !== 1'b1) $display("FAIL err_align_flag got=%0h exp=1", err_align); else passed++;
    total++; if (err_fmt !== 1'b1)   $display("FAIL err_fmt_sticky got=%0h exp=1", err_fmt); else passed++;
    total++; if (count !== 7'd1)     $display("FAIL err_align_count got=%0d exp=1", count); else passed++;
    in_valid = 1'b0;
    do_start();
    total++; if (err_fmt !== 1'b0)   $display("FAIL err_clr_fmt got=%0h exp=0", err_fmt); else passed++;
    total++; if (err_align !== 1'b0) $display("FAIL err_clr_align got=%0h exp=0", err_align); else passed++;
    total++; if (count !== 7'd0)     $display("FAIL err_clr_count got=%0d exp=0", count); else passed++;
    mk(t, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h11);
    apply(t);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b0)    $display("FAIL err_jal_we got=%0h exp=0", mem_we); else passed++;
    total++; if (err_align !== 1'b1) $display("FAIL err_jal_align got=%0h exp=1", err_align); else passed++;
    total++; if (count !== 7'd0)     $display("FAIL err_jal_count got=%0d exp=0", count); else passed++;
  endtask

  task automatic test_start_finish();
    instr_t t;
    do_start();
    for (int i = 0; i < 2; i++) begin
      rand_instr(t);
      apply(t);
      @(negedge clk);
    end
    rand_instr(t);
    apply(t);
    start = 1'b1; finish = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL sf_ready got=%0h exp=0", in_ready); else passed++;
    @(negedge clk);
    start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    total++; if (mem_we !== 1'b0) $display("FAIL sf_we got=%0h exp=0", mem_we); else passed++;
    total++; if (count !== 7'd0)  $display("FAIL sf_count got=%0d exp=0", count); else passed++;
    total++; if (done !== 1'b0)   $display("FAIL sf_done got=%0h exp=0", done); else passed++;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL sf_still_load got=%0h exp=1", in_ready); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL sf_done_late got=%0h exp=0", done); else passed++;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL load_finish_done got=%0h exp=1", done); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0)     $display("FAIL load_finish_pulse got=%0h exp=0", done); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL load_finish_idle got=%0h exp=0", in_ready); else passed++;
  endtask

  task automatic test_reset_inflight();
    instr_t t;
    do_start();
    rand_instr(t);
    apply(t);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (mem_we !== 1'b1) $display("FAIL rst_inflight_pre got=%0h exp=1", mem_we); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (mem_we !== 1'b0) $display("FAIL rst_inflight_we got=%0h exp=0", mem_we); else passed++;
    total++; if (count !== 7'd0)  $display("FAIL rst_inflight_count got=%0d exp=0", count); else passed++;
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_inflight_idle got=%0h exp=0", in_ready); else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_errors();
    test_start_finish();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
